// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared op codes, state encoding and data width for shift_sequencer
package shift_sequencer_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - start/busy/done request bus between the control FSM and shift_sequencer
interface shift_sequencer_if #(
    parameter int W     = 16,
    parameter int AMT_W = 4
);
    logic             start;
    logic [W-1:0]     in;
    logic [1:0]       shift;
    logic [AMT_W-1:0] amount;
    logic             busy;
    logic             done;
    logic [W-1:0]     out;

    modport master (
        output start, in, shift, amount,
        input  busy, done, out
    );

    modport slave (
        input  start, in, shift, amount,
        output busy, done, out
    );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// rtl/shift_sequencer_shifter.sv - existing single-step 16-bit shifter (pass, lsl, lsr, asr by one)
import shift_sequencer_pkg::*;

module shifter #(
    parameter int W = 16
) (
    input  logic [W-1:0] in,
    input  logic [1:0]   shift,
    output logic [W-1:0] sout
);
    always_comb begin
        sout = in;
        case (shift)
            SH_LSL:  sout = {in[W-2:0], 1'b0};
            SH_LSR:  sout = {1'b0, in[W-1:1]};
            SH_ASR:  sout = {in[W-1], in[W-1:1]};
            default: sout = in;
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift-by-N controller iterating the single-step shifter
import shift_sequencer_pkg::*;

module shift_sequencer #(
    parameter int W     = 16,
    parameter int AMT_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_sequencer_if.slave bus
);
    state_e           state_q;
    shift_op_e        op_q;
    logic [W-1:0]     acc_q;
    logic [AMT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     acc_d;

    shifter #(.W(W)) u_shifter (
        .in    (acc_q),
        .shift (op_q),
        .sout  (acc_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= SH_NONE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // DONE behaves as IDLE so a start in the done cycle chains with no gap
                    if (bus.start) begin
                        acc_q <= bus.in;
                        op_q  <= shift_op_e'(bus.shift);
                        cnt_q <= bus.amount;
                        if (bus.amount == '0 || bus.shift == SH_NONE) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = acc_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer against an arithmetic shift model
module tb_shift_sequencer;

    typedef struct {
        logic [15:0] result;
        int          n;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    shift_sequencer_if #(.W(16), .AMT_W(4)) bus ();

    shift_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] model(input logic [15:0] v, input logic [1:0] sh, input int amt);
        logic signed [15:0] s;
        s = v;
        case (sh)
            2'b01:   return v << amt;
            2'b10:   return v >> amt;
            2'b11:   return s >>> amt;
            default: return v;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // caller is at a negedge and knows the DUT is idle or in its done cycle
    task automatic issue(input logic [15:0] v, input logic [1:0] sh, input int amt);
        exp_t e;
        int n;
        n = (amt == 0 || sh == 2'b00) ? 0 : amt;
        e.result   = model(v, sh, amt);
        e.n        = n;
        e.done_cyc = cyc + 1 + n;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.in     = v;
        bus.shift  = sh;
        bus.amount = 4'(amt);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: no done within 60 cycles");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation");
                end else begin
                    e = sb.pop_front();
                    check("out", 32'(bus.out), 32'(e.result));
                    check("busy_cycles", 32'(busy_cnt), 32'(e.n));
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_with_done", 32'(bus.busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        bus.start  = 1'b0;
        bus.in     = '0;
        bus.shift  = '0;
        bus.amount = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_out", 32'(bus.out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        issue(16'hF0CF, 2'b01, 4);  wait_done();
        @(negedge clk);
        issue(16'hF0CF, 2'b10, 3);  wait_done();
        @(negedge clk);
        issue(16'hF0CF, 2'b11, 3);  wait_done();
        issue(16'hFE19, 2'b01, 1);  wait_done();
        check("b2b_out_hold", 32'(bus.out), 32'h0000FC32);
        @(negedge clk);
        issue(16'hA5A5, 2'b01, 0);  wait_done();
        @(negedge clk);
        issue(16'h1234, 2'b00, 7);  wait_done();
        @(negedge clk);

        // start while busy must be ignored
        issue(16'h0001, 2'b01, 15);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.in    = 16'hFFFF;
        bus.shift = 2'b10;
        bus.amount = 4'd2;
        wait_done();
        check("max_out", 32'(bus.out), 32'h00008000);
        @(negedge clk);

        // asynchronous reset mid-operation
        issue(16'hBEEF, 2'b10, 10);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_out", 32'(bus.out), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(16'h8421, 2'b11, 5);  wait_done();
        @(negedge clk);

        for (int k = 0; k < 25; k++) begin
            issue(16'($urandom), 2'($urandom), int'($urandom_range(0, 15)));
            wait_done();
            if ($urandom_range(0, 2) != 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
